i2c_dac_responder: RTL and testbench

//  I2C target (responder) that decodes the MCP47FEB-style DAC write frames issued by our i2c_master-based DAC writer.

---
 rtl/i2c_dac_responder.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_i2c_dac_responder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_dac_responder.sv
// i2c_dac_responder
//   I2C target that decodes MCP47FEB-style DAC write frames, holds two 12-bit
//   channel registers, strobes every committed write and answers register
//   reads. SCL is only sampled (no clock stretching); SDA is open-drain and is
//   pulled low only for ACK bits and for 0 bits of read data.
//
//   Frame formats:
//     write : S, {DEV_ADDR,0}, {reg[4:0],2'b00,x}, {xxxx,d[11:8]}, d[7:0], [cmd,hi,lo]..., P
//     read  : S, {DEV_ADDR,0}, {reg[4:0],2'b11,x}, Sr, {DEV_ADDR,1}, hi, lo, hi, ... , P
//
// Ports
//   clk          system clock, at least 8x the SCL rate
//   rst          synchronous active-high reset
//   i2c_scl_pin  I2C clock, sampled only
//   i2c_sda_pin  I2C data, driven low when sda_drive is set, else released
//   ch0_value    DAC0 channel register
//   ch1_value    DAC1 channel register
//   value_valid  one-cycle pulse when a channel register is committed
//   value_ch     channel of the last commit (0 = DAC0, 1 = DAC1)
//   busy         high from a detected START until a detected STOP
//   cmd_error    one-cycle pulse when a command byte is NACKed
module i2c_dac_responder #(
    parameter logic [6:0]  DEV_ADDR    = 7'b110_0000,
    parameter int          SYNC_STAGES = 2,
    parameter logic [11:0] RESET_VALUE = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire         i2c_scl_pin,
    inout  wire         i2c_sda_pin,
    output logic [11:0] ch0_value,
    output logic [11:0] ch1_value,
    output logic        value_valid,
    output logic        value_ch,
    output logic        busy,
    output logic        cmd_error
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, DHI, DHI_ACK, DLO, DLO_ACK,
        RD_HI, RD_LO, RD_MACK, WAIT_STOP
    } state_t;

    state_t                 state;

    // Line conditioning
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_hist;
    logic                   sda_hist;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;

    // Receive path
    logic [7:0]             shift_reg;
    logic [2:0]             bit_cnt;
    logic                   byte_done;
    logic                   rx_state;
    logic                   cmd_valid;

    // Frame context
    logic                   sda_drive;
    logic                   ptr;
    logic                   rd_op;
    logic                   cmd_read;
    logic [3:0]             data_hi;

    // Transmit path
    logic [7:0]             tx_byte;
    logic [2:0]             tx_cnt;
    logic                   rd_lo;
    logic                   master_ack;
    logic [11:0]            rd_word;
    logic [7:0]             rd_hi_byte;
    logic [7:0]             rd_lo_byte;

    assign i2c_scl_pin = 1'bz;
    assign i2c_sda_pin = sda_drive ? 1'b0 : 1'bz;

    // NOTE: the synchronizers reset to 1 (idle bus level) so that leaving
    // reset on an idle bus cannot be mistaken for a START edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl_pin};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda_pin};
            scl_hist <= scl_sync[SYNC_STAGES-1];
            sda_hist <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist;
    assign scl_fall  = ~scl_s & scl_hist;
    // START/STOP need SCL high in both samples, so they can never coincide
    // with an SCL fall; the commit on the DLO_ACK fall therefore always lands
    // before a following STOP is seen.
    assign start_det = scl_s & scl_hist & sda_hist & ~sda_s;
    assign stop_det  = scl_s & scl_hist & ~sda_hist & sda_s;

    assign rx_state  = (state == ADDR) || (state == CMD) ||
                       (state == DHI)  || (state == DLO);

    // Command byte {reg[4:0], op[1:0], x}: reg must be 0 or 1, op 00 or 11.
    assign cmd_valid = (shift_reg[7:4] == 4'd0) &&
                       ((shift_reg[2:1] == 2'b00) || (shift_reg[2:1] == 2'b11));

    assign rd_word    = ptr ? ch1_value : ch0_value;
    assign rd_hi_byte = {4'b0000, rd_word[11:8]};
    assign rd_lo_byte = rd_word[7:0];

    // NOTE: all state below is updated with non-blocking assignments so every
    // branch sees the pre-edge values of the registers it reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            byte_done   <= 1'b0;
            sda_drive   <= 1'b0;
            ptr         <= 1'b0;
            rd_op       <= 1'b0;
            cmd_read    <= 1'b0;
            data_hi     <= '0;
            tx_byte     <= '0;
            tx_cnt      <= '0;
            rd_lo       <= 1'b0;
            master_ack  <= 1'b0;
            ch0_value   <= RESET_VALUE;
            ch1_value   <= RESET_VALUE;
            value_valid <= 1'b0;
            value_ch    <= 1'b0;
            busy        <= 1'b0;
            cmd_error   <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            cmd_error   <= 1'b0;

            if (start_det) begin
                state     <= ADDR;
                busy      <= 1'b1;
                sda_drive <= 1'b0;
                shift_reg <= '0;
                bit_cnt   <= '0;
                byte_done <= 1'b0;
            end else if (stop_det) begin
                state     <= IDLE;
                busy      <= 1'b0;
                sda_drive <= 1'b0;
                bit_cnt   <= '0;
                byte_done <= 1'b0;
            end else begin
                // Bits are taken on SCL rise, MSB first; the ninth (ACK)
                // clock is not shifted, so shift_reg still holds the byte
                // while its ACK is being driven.
                if (scl_rise && rx_state) begin
                    shift_reg <= {shift_reg[6:0], sda_s};
                    bit_cnt   <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_done <= 1'b1;
                    end
                end

                if (scl_rise && (state == RD_MACK)) begin
                    master_ack <= ~sda_s;
                end

                if (scl_fall) begin
                    case (state)
                        ADDR: begin
                            if (byte_done) begin
                                byte_done <= 1'b0;
                                if (shift_reg[7:1] == DEV_ADDR) begin
                                    rd_op     <= shift_reg[0];
                                    sda_drive <= 1'b1;
                                    state     <= ADDR_ACK;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end
                        end
                        ADDR_ACK: begin
                            if (rd_op) begin
                                // First data bit goes out on the same fall
                                // that ends the address ACK.
                                tx_byte   <= rd_hi_byte;
                                tx_cnt    <= '0;
                                rd_lo     <= 1'b0;
                                sda_drive <= ~rd_hi_byte[7];
                                state     <= RD_HI;
                            end else begin
                                sda_drive <= 1'b0;
                                state     <= CMD;
                            end
                        end
                        CMD: begin
                            if (byte_done) begin
                                byte_done <= 1'b0;
                                if (cmd_valid) begin
                                    ptr       <= shift_reg[3];
                                    cmd_read  <= shift_reg[2];
                                    sda_drive <= 1'b1;
                                    state     <= CMD_ACK;
                                end else begin
                                    cmd_error <= 1'b1;
                                    state     <= WAIT_STOP;
                                end
                            end
                        end
                        CMD_ACK: begin
                            sda_drive <= 1'b0;
                            // A read command only sets the pointer; the data
                            // follows after a repeated START.
                            state     <= cmd_read ? WAIT_STOP : DHI;
                        end
                        DHI: begin
                            if (byte_done) begin
                                byte_done <= 1'b0;
                                data_hi   <= shift_reg[3:0];
                                sda_drive <= 1'b1;
                                state     <= DHI_ACK;
                            end
                        end
                        DHI_ACK: begin
                            sda_drive <= 1'b0;
                            state     <= DLO;
                        end
                        DLO: begin
                            if (byte_done) begin
                                byte_done <= 1'b0;
                                sda_drive <= 1'b1;
                                state     <= DLO_ACK;
                            end
                        end
                        DLO_ACK: begin
                            sda_drive   <= 1'b0;
                            value_valid <= 1'b1;
                            value_ch    <= ptr;
                            if (ptr) begin
                                ch1_value <= {data_hi, shift_reg};
                            end else begin
                                ch0_value <= {data_hi, shift_reg};
                            end
                            state <= CMD;
                        end
                        RD_HI, RD_LO: begin
                            if (tx_cnt == 3'd7) begin
                                sda_drive <= 1'b0;
                                state     <= RD_MACK;
                            end else begin
                                tx_byte   <= {tx_byte[6:0], 1'b0};
                                sda_drive <= ~tx_byte[6];
                                tx_cnt    <= tx_cnt + 3'd1;
                            end
                        end
                        RD_MACK: begin
                            if (master_ack) begin
                                tx_cnt <= '0;
                                if (rd_lo) begin
                                    tx_byte   <= rd_hi_byte;
                                    sda_drive <= ~rd_hi_byte[7];
                                    rd_lo     <= 1'b0;
                                    state     <= RD_HI;
                                end else begin
                                    tx_byte   <= rd_lo_byte;
                                    sda_drive <= ~rd_lo_byte[7];
                                    rd_lo     <= 1'b1;
                                    state     <= RD_LO;
                                end
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                        IDLE, WAIT_STOP: ;
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_dac_responder.sv
// tb_i2c_dac_responder
//   Bit-banged I2C master driving i2c_dac_responder over a pulled-up
//   open-drain bus. A frame-level reference model (two channel registers
//   plus a pointer) predicts every ACK, every read byte, every commit strobe
//   and every command error.
module tb_i2c_dac_responder;

    localparam logic [6:0]  DEV_ADDR    = 7'b110_0000;
    localparam logic [11:0] RESET_VALUE = 12'h000;
    localparam int          Q           = 5;   // clocks between SCL-low events
    localparam int          H           = 8;   // clocks SCL stays high

    typedef logic [7:0] byte_q_t [$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_low = 1'b0;
    logic        sda_low = 1'b0;
    wire         scl_bus;
    wire         sda_bus;
    logic [11:0] ch0_value;
    logic [11:0] ch1_value;
    logic        value_valid;
    logic        value_ch;
    logic        busy;
    logic        cmd_error;

    assign scl_bus = scl_low ? 1'b0 : 1'bz;
    assign sda_bus = sda_low ? 1'b0 : 1'bz;
    pullup (scl_bus);
    pullup (sda_bus);

    i2c_dac_responder #(
        .DEV_ADDR    (DEV_ADDR),
        .SYNC_STAGES (2),
        .RESET_VALUE (RESET_VALUE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i2c_scl_pin (scl_bus),
        .i2c_sda_pin (sda_bus),
        .ch0_value   (ch0_value),
        .ch1_value   (ch1_value),
        .value_valid (value_valid),
        .value_ch    (value_ch),
        .busy        (busy),
        .cmd_error   (cmd_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model state
    logic [11:0] m_reg [2];
    logic        m_ptr;

    // Observed strobes and errors
    logic [12:0] obs_q [$];
    int          err_seen;
    byte_q_t     fq;

    always @(negedge clk) begin
        if (value_valid) obs_q.push_back({value_ch, value_ch ? ch1_value : ch0_value});
        if (cmd_error) err_seen++;
    end

    initial begin
        #950_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add(input logic [7:0] b);
        fq.push_back(b);
    endtask

    // Works from idle (START) and from SCL low mid-frame (repeated START).
    task automatic bus_start();
        sda_low = 1'b0; clks(Q);
        scl_low = 1'b0; clks(Q);
        sda_low = 1'b1; clks(Q);
        scl_low = 1'b1; clks(Q);
    endtask

    task automatic bus_stop();
        sda_low = 1'b1; clks(Q);
        scl_low = 1'b0; clks(Q);
        sda_low = 1'b0; clks(Q);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_low = ~b[i]; clks(Q);
            scl_low = 1'b0;  clks(H);
            scl_low = 1'b1;  clks(Q);
        end
        sda_low = 1'b0;
    endtask

    task automatic ack_clock(output bit acked);
        sda_low = 1'b0; clks(Q);
        scl_low = 1'b0; clks(H / 2);
        acked = (sda_bus === 1'b0);
        clks(H / 2);
        scl_low = 1'b1; clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output bit acked);
        send_bits(b);
        ack_clock(acked);
    endtask

    task automatic read_byte(input bit give_ack, output logic [7:0] b);
        sda_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            scl_low = 1'b0; clks(H / 2);
            b[i] = sda_bus;
            clks(H / 2);
            scl_low = 1'b1; clks(Q);
        end
        sda_low = give_ack; clks(Q);
        scl_low = 1'b0;     clks(H);
        scl_low = 1'b1;     clks(2);
        sda_low = 1'b0;     clks(Q);
    endtask

    // Sends fq as one write frame and checks it against the model.
    task automatic write_frame(input string tag);
        bit          live;
        int          phase;
        int          exp_err;
        logic [3:0]  hi;
        logic [7:0]  b;
        bit          acked;
        bit          exp_ack;
        logic [12:0] exp_q [$];
        obs_q.delete();
        err_seen = 0;
        exp_err  = 0;
        live     = 1'b0;
        phase    = 0;
        hi       = '0;
        bus_start();
        for (int i = 0; i < fq.size(); i++) begin
            b = fq[i];
            if (i == 0) begin
                exp_ack = (b[7:1] == DEV_ADDR) && !b[0];
                live    = exp_ack;
            end else if (!live) begin
                exp_ack = 1'b0;
            end else if (phase == 0) begin
                if ((b[7:3] < 5'd2) && (b[2:1] == 2'b00 || b[2:1] == 2'b11)) begin
                    exp_ack = 1'b1;
                    m_ptr   = b[3];
                    live    = (b[2:1] == 2'b00);
                    phase   = 1;
                end else begin
                    exp_ack = 1'b0;
                    live    = 1'b0;
                    exp_err++;
                end
            end else if (phase == 1) begin
                exp_ack = 1'b1;
                hi      = b[3:0];
                phase   = 2;
            end else begin
                exp_ack = 1'b1;
                m_reg[m_ptr] = {hi, b};
                exp_q.push_back({m_ptr, hi, b});
                phase   = 0;
            end
            write_byte(b, acked);
            check($sformatf("%s ack%0d", tag, i), acked, exp_ack);
        end
        check({tag, " busy before stop"}, busy, 1);
        bus_stop();
        clks(4);
        check({tag, " busy after stop"}, busy, 0);
        check({tag, " strobe count"}, obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            check($sformatf("%s commit%0d", tag, k), obs_q[k], exp_q[k]);
        if (exp_q.size() > 0) check({tag, " value_ch held"}, value_ch, exp_q[exp_q.size()-1][12]);
        check({tag, " cmd_error count"}, err_seen, exp_err);
        check({tag, " ch0"}, ch0_value, m_reg[0]);
        check({tag, " ch1"}, ch1_value, m_reg[1]);
    endtask

    // Optional pointer setup, repeated START, then n read bytes.
    task automatic read_frame(input string tag, input bit setup, input logic p,
                              input logic x, input int n);
        bit         acked;
        logic [7:0] got;
        logic [7:0] exp;
        obs_q.delete();
        err_seen = 0;
        bus_start();
        if (setup) begin
            write_byte({DEV_ADDR, 1'b0}, acked);
            check({tag, " waddr ack"}, acked, 1);
            write_byte({4'b0000, p, 2'b11, x}, acked);
            check({tag, " rcmd ack"}, acked, 1);
            m_ptr = p;
            bus_start();
        end
        write_byte({DEV_ADDR, 1'b1}, acked);
        check({tag, " raddr ack"}, acked, 1);
        for (int k = 0; k < n; k++) begin
            read_byte(k != n - 1, got);
            exp = (k % 2 == 0) ? {4'b0000, m_reg[m_ptr][11:8]} : m_reg[m_ptr][7:0];
            check($sformatf("%s rd%0d", tag, k), got, exp);
        end
        bus_stop();
        clks(4);
        check({tag, " busy after stop"}, busy, 0);
        check({tag, " no strobe"}, obs_q.size(), 0);
        check({tag, " no cmd_error"}, err_seen, 0);
    endtask

    initial begin
        bit          acked;
        logic [7:0]  cmd;
        logic [6:0]  a7;
        logic [11:0] v;
        int          kind;
        int          groups;

        m_reg[0] = RESET_VALUE;
        m_reg[1] = RESET_VALUE;
        m_ptr    = 1'b0;

        clks(6);
        check("reset ch0", ch0_value, RESET_VALUE);
        check("reset ch1", ch1_value, RESET_VALUE);
        check("reset value_valid", value_valid, 0);
        check("reset value_ch", value_ch, 0);
        check("reset busy", busy, 0);
        check("reset cmd_error", cmd_error, 0);
        check("reset sda released", sda_bus, 1);
        rst = 1'b0;
        clks(6);

        fq.delete(); add(8'hC0); add(8'h00); add(8'h0B); add(8'hCD);
        write_frame("T1");
        check("T1 ch0 literal", ch0_value, 12'hBCD);

        read_frame("T3", 1'b1, 1'b0, 1'b0, 2);

        fq.delete(); add(8'hC0); add(8'h00); add(8'h01); add(8'h23);
        add(8'h08); add(8'h04); add(8'h56);
        write_frame("T2");
        check("T2 ch1 literal", ch1_value, 12'h456);

        fq.delete(); add(8'hC2); add(8'h00); add(8'h0B); add(8'hCD);
        write_frame("T4 bad addr");
        fq.delete(); add(8'hC0); add(8'h10); add(8'h0A); add(8'hBC);
        write_frame("T4 bad cmd");

        fq.delete(); add(8'hC0); add(8'h00); add(8'h0F);
        write_frame("T5 abort");

        // T6: reset while the DHI ACK is on the bus
        obs_q.delete();
        bus_start();
        write_byte(8'hC0, acked);
        check("T6 addr ack", acked, 1);
        write_byte(8'h00, acked);
        check("T6 cmd ack", acked, 1);
        send_bits(8'h0A);
        clks(Q);
        check("T6 ack driven", sda_bus, 0);
        rst = 1'b1;
        clks(1);
        check("T6 sda released", sda_bus, 1);
        check("T6 busy", busy, 0);
        check("T6 ch0", ch0_value, RESET_VALUE);
        check("T6 ch1", ch1_value, RESET_VALUE);
        check("T6 value_ch", value_ch, 0);
        check("T6 value_valid", value_valid, 0);
        rst = 1'b0;
        m_reg[0] = RESET_VALUE;
        m_reg[1] = RESET_VALUE;
        m_ptr    = 1'b0;
        scl_low  = 1'b0;
        clks(Q);
        check("T6 no strobe", obs_q.size(), 0);
        fq.delete(); add(8'hC0); add(8'h08); add(8'h07); add(8'h89);
        write_frame("T6 post");
        check("T6 post ch1 literal", ch1_value, 12'h789);

        for (int it = 0; it < 20; it++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 4) begin
                fq.delete();
                add({DEV_ADDR, 1'b0});
                groups = $urandom_range(1, 3);
                for (int g = 0; g < groups; g++) begin
                    cmd = {4'b0000, 1'($urandom_range(0, 1)), 2'b00, 1'($urandom_range(0, 1))};
                    if ($urandom_range(0, 5) == 0) cmd = 8'($urandom);
                    v = 12'($urandom);
                    add(cmd);
                    add({4'($urandom), v[11:8]});
                    add(v[7:0]);
                end
                if ($urandom_range(0, 4) == 0) void'(fq.pop_back());
                write_frame($sformatf("rnd%0d wr", it));
            end else if (kind <= 8) begin
                read_frame($sformatf("rnd%0d rd", it), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           $urandom_range(1, 4));
            end else begin
                a7 = 7'($urandom);
                if (a7 == DEV_ADDR) a7 = a7 ^ 7'h01;
                fq.delete();
                add({a7, 1'b0}); add(8'($urandom)); add(8'($urandom));
                write_frame($sformatf("rnd%0d badaddr", it));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
